apb2axi_wr_scheduler: RTL

Round-robin scheduler placed between N_SRC write-command FIFOs and the single AXI write builder. It grants one FIFO entry at a time, allocates a free AXI ID slot for each issued write, and caps in-flight writes at MAX_OST. It snoops the AXI B channel to free slots and returns each completion, tagged with its source, to the requester that issued it.

---
 rtl/apb2axi_pkg.sv | 20 ++
 rtl/apb2axi_rr_arbiter.sv | 32 +++
 rtl/apb2axi_wr_scheduler.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI bridge.
// The write scheduler's FSM states and slot-table entries are defined here.
package apb2axi_pkg;

    localparam int CMD_ENTRY_W      = 32;
    localparam int APB2AXI_ID_W     = 4;
    localparam int WR_SCHED_MAX_OST = 4;
    localparam int WR_SCHED_SRC_W   = 3;  // wide enough for up to 8 sources

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } wr_sched_state_e;

    typedef struct packed {
        logic                      busy;
        logic [WR_SCHED_SRC_W-1:0] src;
    } wr_slot_t;

endpackage

// File: rtl/apb2axi_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or above ptr,
// wrapping modulo N. Shared by the read and write schedulers.
module apb2axi_rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop so no latch is inferred.
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) idx = idx - N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/apb2axi_wr_scheduler.sv
// Round-robin write scheduler: pops one FIFO entry at a time, assigns it a free
// AXI ID slot, and routes each B response back to the source that issued it.
module apb2axi_wr_scheduler
    import apb2axi_pkg::*;
#(
    parameter  int N_SRC        = 2,
    parameter  int MAX_OST      = WR_SCHED_MAX_OST,
    parameter  int FIFO_ENTRY_W = CMD_ENTRY_W,
    parameter  int AXI_ID_W     = APB2AXI_ID_W,
    localparam int SRC_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    localparam int OST_W        = $clog2(MAX_OST + 1)
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [N_SRC-1:0]              src_vld,
    output logic [N_SRC-1:0]              src_rdy,
    input  logic [N_SRC*FIFO_ENTRY_W-1:0] src_data,
    output logic                          bld_vld,
    input  logic                          bld_rdy,
    output logic [FIFO_ENTRY_W-1:0]       bld_data,
    output logic [AXI_ID_W-1:0]           bld_id,
    input  logic                          bvalid,
    output logic                          bready,
    input  logic [AXI_ID_W-1:0]           bid,
    input  logic [1:0]                    bresp,
    output logic                          cmp_vld,
    input  logic                          cmp_rdy,
    output logic [SRC_W-1:0]              cmp_src,
    output logic [1:0]                    cmp_resp,
    output logic [OST_W-1:0]              ost_cnt,
    output logic                          err_unexp_b
);

    localparam int                SLOT_W     = (MAX_OST > 1) ? $clog2(MAX_OST) : 1;
    localparam logic [AXI_ID_W:0] MAX_OST_ID = (AXI_ID_W + 1)'(MAX_OST);

    wr_sched_state_e   r_state, w_state_nxt;
    wr_slot_t          r_slot [MAX_OST];
    logic [SRC_W-1:0]  r_rr_ptr;

    logic [N_SRC-1:0]  w_gnt;
    logic [SRC_W-1:0]  w_gnt_idx;
    logic              w_any_req;
    logic              w_any_free;
    logic [SLOT_W-1:0] w_free_idx;
    logic              w_grant;
    logic [SLOT_W-1:0] w_bid_slot;
    logic              w_b_hs;
    logic              w_b_free;

    apb2axi_rr_arbiter #(.N(N_SRC)) u_arb (
        .req     (src_vld),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any_req)
    );

    // Descending scan so the last hit, the lowest free index, wins.
    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        for (int i = MAX_OST - 1; i >= 0; i--) begin
            if (!r_slot[i].busy) begin
                w_any_free = 1'b1;
                w_free_idx = SLOT_W'(i);
            end
        end
    end

    assign w_grant    = (r_state == IDLE) && w_any_req && w_any_free;
    assign w_bid_slot = bid[SLOT_W-1:0];
    assign bready     = !cmp_vld || cmp_rdy;
    assign w_b_hs     = bvalid && bready;
    assign w_b_free   = w_b_hs && ({1'b0, bid} < MAX_OST_ID) && r_slot[w_bid_slot].busy;
    assign bld_vld    = (r_state == ISSUE);

    always_comb begin
        w_state_nxt = r_state;
        src_rdy     = '0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    src_rdy     = w_gnt;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bld_rdy) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (areset) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            bld_data <= '0;
            bld_id   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                bld_data <= src_data[w_gnt_idx*FIFO_ENTRY_W +: FIFO_ENTRY_W];
                bld_id   <= AXI_ID_W'(w_free_idx);
                r_rr_ptr <= (w_gnt_idx == SRC_W'(N_SRC - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    // A freed slot is always busy and an allocated one always free, so they never collide.
    always_ff @(posedge aclk) begin
        for (int i = 0; i < MAX_OST; i++) begin
            // NOTE: the slot table is reset explicitly because a stale busy bit would leak an ID forever.
            if (areset) begin
                r_slot[i] <= '0;
            end else begin
                if (w_b_free && (w_bid_slot == SLOT_W'(i))) r_slot[i].busy <= 1'b0;
                if (w_grant && (w_free_idx == SLOT_W'(i))) begin
                    r_slot[i].busy <= 1'b1;
                    r_slot[i].src  <= WR_SCHED_SRC_W'(w_gnt_idx);
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ost_cnt <= '0;
        end else begin
            ost_cnt <= ost_cnt + OST_W'(w_grant) - OST_W'(w_b_free);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cmp_vld     <= 1'b0;
            cmp_src     <= '0;
            cmp_resp    <= '0;
            err_unexp_b <= 1'b0;
        end else begin
            if (w_b_free) begin
                cmp_vld  <= 1'b1;
                cmp_src  <= r_slot[w_bid_slot].src[SRC_W-1:0];
                cmp_resp <= bresp;
            end else if (cmp_rdy) begin
                cmp_vld <= 1'b0;
            end
            if (w_b_hs && !w_b_free) err_unexp_b <= 1'b1;
        end
    end

endmodule
